// File: rtl/sign_sched_ctrl.sv
// rtl/sign_sched_ctrl.sv - challenge expansion, packer handshake and sigma word streaming
// Optional watchdog on RUN/SEND enabled by SIGN_SCHED_TIMEOUT_EN.
module sign_sched_ctrl #(
  parameter int T       = 8,
  parameter int TAU     = 4,
  parameter int NP      = 16,
  parameter int WORD_W  = 64,
  parameter int SIGMA_W = 19584,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [255:0]         h_t,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [TAU*5-1:0]     lc,
  output logic [TAU*5-1:0]     lp,
  output logic                 gs_start,
  input  logic                 gs_end,
  input  logic [SIGMA_W-1:0]   sigma_in,
  output logic [WORD_W-1:0]    sig_data,
  output logic                 sig_valid,
  input  logic                 sig_ready,
  output logic                 sig_last
);
  localparam int LCB    = $clog2(T);
  localparam int LPB    = $clog2(NP);
  localparam int NWORDS = SIGMA_W / WORD_W;
  localparam int KW     = $clog2(NWORDS);
  localparam int CW     = $clog2(TAU);

  typedef enum logic [2:0] {IDLE, EXP_C, EXP_P, RUN, SEND, ERR} state_t;
  state_t state, state_n;

  logic [255:0]       hreg;
  logic [8:0]         ptr;
  logic [CW-1:0]      cnt;
  logic [KW-1:0]      k;
  logic [SIGMA_W-1:0] sreg;
  logic [LCB-1:0]     lc_r [TAU];
  logic [LPB-1:0]     lp_r [TAU];
  logic [LCB-1:0]     v_c;
  logic [LPB-1:0]     v_p;
  logic               dup, c_exh, p_exh, last_cnt, last_word;

`ifdef SIGN_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd;
  logic           wd_hit;
  assign wd_hit = (wd == WDW'(TIMEOUT - 1));
`endif

  // hreg is consumed by shifting, so the next draw always sits in the MSBs
  always_comb begin
    v_c       = hreg[255 -: LCB];
    v_p       = hreg[255 -: LPB];
    c_exh     = ptr > 9'(256 - LCB);
    p_exh     = ptr > 9'(256 - LPB);
    last_cnt  = (cnt == CW'(TAU - 1));
    last_word = (k == KW'(NWORDS - 1));
    dup       = 1'b0;
    for (int i = 0; i < TAU; i++)
      if (i < int'(cnt) && lc_r[i] == v_c) dup = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = EXP_C;
      EXP_C: begin
        if (c_exh) state_n = ERR;
        else if (!dup && last_cnt) state_n = EXP_P;
      end
      EXP_P: begin
        if (p_exh) state_n = ERR;
        else if (last_cnt) state_n = RUN;
      end
      RUN: begin
        if (gs_end) state_n = SEND;
`ifdef SIGN_SCHED_TIMEOUT_EN
        else if (wd_hit) state_n = ERR;
`endif
      end
      SEND: begin
        if (sig_ready) begin
          if (last_word) state_n = IDLE;
        end
`ifdef SIGN_SCHED_TIMEOUT_EN
        else if (wd_hit) state_n = ERR;
`endif
      end
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    gs_start  = (state == RUN);
    sig_valid = (state == SEND);
    sig_last  = sig_valid && last_word;
    sig_data  = sig_valid ? sreg[SIGMA_W-1 -: WORD_W] : '0;
    lc        = '0;
    lp        = '0;
    for (int i = 0; i < TAU; i++) begin
      lc[(TAU-1-i)*5 +: 5] = 5'(lc_r[i]);
      lp[(TAU-1-i)*5 +: 5] = 5'(lp_r[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hreg <= '0;
      ptr  <= '0;
      cnt  <= '0;
      k    <= '0;
      sreg <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      for (int i = 0; i < TAU; i++) begin
        lc_r[i] <= '0;
        lp_r[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (state != ERR && state_n == ERR) err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          hreg <= h_t;
          err  <= 1'b0;
          ptr  <= '0;
          cnt  <= '0;
          k    <= '0;
          for (int i = 0; i < TAU; i++) begin
            lc_r[i] <= '0;
            lp_r[i] <= '0;
          end
        end
        EXP_C: if (!c_exh) begin
          hreg <= hreg << LCB;
          ptr  <= ptr + 9'(LCB);
          if (!dup) begin
            lc_r[cnt] <= v_c;
            cnt       <= last_cnt ? '0 : cnt + 1'b1;
          end
        end
        EXP_P: if (!p_exh) begin
          hreg      <= hreg << LPB;
          ptr       <= ptr + 9'(LPB);
          lp_r[cnt] <= v_p;
          cnt       <= last_cnt ? '0 : cnt + 1'b1;
        end
        RUN: if (gs_end) begin
          sreg <= sigma_in;
          k    <= '0;
        end
        SEND: if (sig_ready) begin
          sreg <= sreg << WORD_W;
          if (last_word) done <= 1'b1;
          else           k    <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SIGN_SCHED_TIMEOUT_EN
  // counts consecutive stalled cycles; any state change restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                      wd <= '0;
    else if (state_n != state)                                       wd <= '0;
    else if ((state == RUN && !gs_end) || (state == SEND && !sig_ready)) wd <= wd + 1'b1;
    else                                                             wd <= '0;
  end
`endif
endmodule
